// File: rtl/spram_access_arbiter_if.sv
// Client-side bus of the frame-RAM arbiter: UART write path, VGA read path
// and the frame-start pulse.
//   master : the client (writer/reader); drives requests, sees ready/read data
//   slave  : the arbiter
// Ports carried:
//   frame_start          1-cycle frame restart pulse
//   wr_valid/wr_data     pixel write strobe and data
//   wr_ready             arbiter can take a pixel
//   rd_req/rd_addr       pixel read request and linear address
//   rd_data/rd_valid     returned pixel, two cycles after rd_req
interface spram_access_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 12
);
    logic              frame_start;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output frame_start, wr_valid, wr_data, rd_req, rd_addr,
        input  wr_ready, rd_data, rd_valid
    );

    modport slave (
        input  frame_start, wr_valid, wr_data, rd_req, rd_addr,
        output wr_ready, rd_data, rd_valid
    );
endinterface

// File: rtl/spram_access_arbiter.sv
// Single owner of the single-port frame RAM. Multiplexes the VGA pixel read
// path (absolute priority) and the UART pixel write path (buffered in a FIFO,
// retired in cycles without a read) onto one RAM port, one access per clock.
// Tracks the frame write pointer and flags frame completion.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   bus (slave)     frame_start, wr_valid/wr_data/wr_ready,
//                   rd_req/rd_addr/rd_data/rd_valid
//   spram_addr      RAM address (registered)
//   spram_wr_data   RAM write data (registered)
//   spram_wre       RAM write enable
//   spram_rd_data   RAM read data, 1-cycle synchronous latency
//   pix_cnt         pixels committed this frame
//   fifo_cnt        write FIFO occupancy
//   frame_done      all W*H pixels committed
//
// Optional build macro SPRAM_ARB_STATS_EN adds drop_cnt (writes offered while
// not ready) and stall_cnt (cycles a pending write lost to a read), both
// saturating, cleared by rst or frame_start.
module spram_access_arbiter #(
    parameter int W          = 160,
    parameter int H          = 120,
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    spram_access_arbiter_if.slave bus,
    output logic [ADDR_W-1:0] spram_addr,
    output logic [DATA_W-1:0] spram_wr_data,
    output logic              spram_wre,
    input  logic [DATA_W-1:0] spram_rd_data,
    output logic [ADDR_W-1:0] pix_cnt,
    output logic [7:0]        fifo_cnt,
    output logic              frame_done
`ifdef SPRAM_ARB_STATS_EN
    ,
    output logic [15:0]       drop_cnt,
    output logic [15:0]       stall_cnt
`endif
);
    localparam int PIX = W * H;
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

    state_t            state, next_state;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wptr, rptr;
    logic              ready_en;
    logic [2:0]        vld_pipe;
    logic              fifo_full, fifo_empty, push, pop, last_pix;

    assign fifo_full  = (fifo_cnt == 8'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == 8'd0);
    assign last_pix   = (pix_cnt == ADDR_W'(PIX - 1));

    // ready_en keeps wr_ready low through reset and lifts it one edge later.
    assign bus.wr_ready = ready_en & ~fifo_full & ~frame_done;
    assign push         = bus.wr_valid & bus.wr_ready & ~bus.frame_start;
    assign pop          = (next_state == S_WR);

    // ---------------- grant FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = S_IDLE;
        if (bus.rd_req)
            next_state = S_RD;
        else if (!fifo_empty && !frame_done && !bus.frame_start)
            next_state = S_WR;
    end

    // A write already granted is cancelled if frame_start lands on its cycle.
    always_comb begin
        spram_wre = 1'b0;
        if (state == S_WR && !bus.frame_start)
            spram_wre = 1'b1;
    end

    // RAM address/data are loaded on the edge that grants the access; in idle
    // cycles they simply hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spram_addr    <= '0;
            spram_wr_data <= '0;
        end else if (next_state == S_RD) begin
            spram_addr    <= bus.rd_addr;
        end else if (next_state == S_WR) begin
            spram_addr    <= pix_cnt;
            spram_wr_data <= fifo_mem[rptr];
        end
    end

    // ---------------- write FIFO and frame pointer ----------------
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wptr] <= bus.wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en   <= 1'b0;
            wptr       <= '0;
            rptr       <= '0;
            fifo_cnt   <= '0;
            pix_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (bus.frame_start) begin
                wptr       <= '0;
                rptr       <= '0;
                fifo_cnt   <= '0;
                pix_cnt    <= '0;
                frame_done <= 1'b0;
            end else begin
                if (push) wptr <= wptr + PW'(1);
                if (pop) begin
                    rptr    <= rptr + PW'(1);
                    pix_cnt <= pix_cnt + ADDR_W'(1);
                end
                if (pop && last_pix) begin
                    // Frame complete: anything still buffered is surplus.
                    frame_done <= 1'b1;
                    wptr       <= '0;
                    rptr       <= '0;
                    fifo_cnt   <= '0;
                end else begin
                    fifo_cnt <= fifo_cnt + {7'd0, push} - {7'd0, pop};
                end
            end
        end
    end

    // ---------------- read return pipe ----------------
    // [0]: address registered, [1]: RAM data out, [2]: rd_data registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe    <= '0;
            bus.rd_data <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1:0], bus.rd_req};
            if (vld_pipe[1]) bus.rd_data <= spram_rd_data;
        end
    end

    assign bus.rd_valid = vld_pipe[2];

`ifdef SPRAM_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt  <= '0;
            stall_cnt <= '0;
        end else if (bus.frame_start) begin
            drop_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (bus.wr_valid && !bus.wr_ready && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
            if (!fifo_empty && bus.rd_req && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: doc/spram_access_arbiter.md
Name: spram_access_arbiter

Overview:
- Single owner of the 15-bit x 12-bit single-port frame RAM; time-multiplexes the UART image-write path and the VGA pixel-read path onto one port.
- One access per clock. The VGA read has absolute priority; writes are absorbed in a small FIFO and retired in idle cycles.
- Tracks the frame write pointer and signals frame completion, replacing ad-hoc wr_req/rd_req handling in the writer and reader.

Parameters:
- W, 160, image width in pixels
- H, 120, image height in pixels
- ADDR_W, 15, SPRAM address width; W*H must be <= 2**ADDR_W
- DATA_W, 12, pixel width (RGB444)
- FIFO_DEPTH, 8, write buffer depth; power of two, 2..64

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- frame_start  in  1  1-cycle pulse: flush write FIFO, write pointer to 0, clear frame_done
- wr_valid  in  1  write-pixel strobe from UART assembler
- wr_data  in  DATA_W  pixel to store
- wr_ready  out  1  FIFO can accept; high when not full and frame_done low
- rd_req  in  1  VGA read request, 1 cycle per pixel
- rd_addr  in  ADDR_W  linear pixel address (y*W + x), computed by VGA
- rd_data  out  DATA_W  returned pixel
- rd_valid  out  1  rd_data valid
- spram_addr  out  ADDR_W  RAM address
- spram_wr_data  out  DATA_W  RAM write data
- spram_wre  out  1  RAM write enable
- spram_rd_data  in  DATA_W  RAM read data, 1-cycle synchronous latency
- pix_cnt  out  ADDR_W  pixels committed to RAM this frame
- fifo_cnt  out  8  current FIFO occupancy
- frame_done  out  1  level; all W*H pixels committed

Behaviour:
- Reset (async, rst=1): all outputs 0. FIFO empty, pointer 0, grant state S_IDLE. wr_ready rises the first cycle after rst deasserts.
- Grant FSM, evaluated every edge; states S_IDLE, S_RD, S_WR:
  - rd_req=1 -> S_RD
  - else if FIFO non-empty and not frame_done -> S_WR
  - else -> S_IDLE
- S_RD: spram_addr=rd_addr registered, spram_wre=0.
- S_WR: spram_addr=pix_cnt, spram_wr_data=FIFO head, spram_wre=1. Pop the FIFO and increment pix_cnt at the same edge.
- S_IDLE: spram_wre=0, spram_addr holds its last value.
- Read latency: rd_req sampled at edge N; RAM address driven after N; rd_data/rd_valid registered, high for the cycle after edge N+2. Fixed at 2 cycles, never stalled. Back-to-back rd_req gives back-to-back rd_valid.
- Writes accepted on wr_valid & wr_ready (push). wr_valid while wr_ready=0: data dropped, no state change.
- Push and pop in the same cycle: fifo_cnt unchanged. Full (fifo_cnt=FIFO_DEPTH) drops wr_ready the same cycle, combinationally.
- Write to pixel W*H-1 commits: frame_done set next edge. wr_ready forced low; further FIFO contents are discarded. pix_cnt holds at W*H.
- frame_start: FIFO flushed, pix_cnt=0, frame_done=0 at the next edge. It overrides a same-cycle push (push dropped) and a same-cycle S_WR (the write to RAM is suppressed, spram_wre=0). A same-cycle rd_req is still served.
- Continuous rd_req starves writes indefinitely by design. The VGA leaves blanking gaps that drain the FIFO.
- rst mid-frame: pointer and FIFO lost; pending rd_valid cancelled.

Optional Feature:
- Macro SPRAM_ARB_STATS_EN.
- Defined:
  - adds outputs drop_cnt (16) and stall_cnt (16)
  - drop_cnt increments on each wr_valid & !wr_ready
  - stall_cnt increments on each cycle with FIFO non-empty and rd_req=1
  - both saturate at 16'hFFFF and clear on rst or frame_start
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset: rst=1 mid-stream -> all outputs 0. One cycle after release, wr_ready=1 and fifo_cnt=0.
- W=3, H=2, 6 wr_valid pulses 12'h001..12'h006, no rd_req -> spram_wre pulses at addresses 0..5 with data 001..006 in order. frame_done=1, pix_cnt=6, wr_ready=0.
- FIFO fill: hold rd_req=1 continuously and push 9 pixels -> first 8 accepted, fifo_cnt=8, wr_ready=0, 9th dropped (drop_cnt=1 with SPRAM_ARB_STATS_EN). Drop rd_req -> 8 writes on consecutive cycles.
- Read priority: RAM preloaded, rd_req at address 4 in the same cycle FIFO holds 1 pixel -> S_RD first. rd_valid 2 cycles later with the address-4 data; the write follows the next cycle.
- Streaming read: rd_req held 6 cycles, rd_addr 0..5 -> rd_valid high 6 consecutive cycles starting 2 cycles later, data in address order, spram_wre=0 throughout.
- frame_start with fifo_cnt=3 and frame_done=0 -> next edge fifo_cnt=0, pix_cnt=0; no spram_wre that cycle. A following write lands at address 0.
